// File: rtl/pin_entry_collector_if.sv
// Keypad/controller-side bundle for the PIN entry collector.
// master drives the keypad and card signals; slave is the collector itself.
interface pin_entry_collector_if #(
  parameter int N_DIGITS = 4
);
  logic                    tarjeta_recibida;
  logic [4*N_DIGITS-1:0]   pin_ref;
  logic [3:0]              digito;
  logic                    digito_stb;
  logic                    borrar;
  logic                    reintento;
  logic [4*N_DIGITS-1:0]   pin_ingresado;
  logic                    pin_listo;
  logic                    pin_correcto;
  logic [2:0]              cuenta_digitos;
  logic                    digito_invalido;
  logic                    timeout_err;

  modport master (
    output tarjeta_recibida, pin_ref, digito, digito_stb, borrar, reintento,
    input  pin_ingresado, pin_listo, pin_correcto, cuenta_digitos,
           digito_invalido, timeout_err
  );

  modport slave (
    input  tarjeta_recibida, pin_ref, digito, digito_stb, borrar, reintento,
    output pin_ingresado, pin_listo, pin_correcto, cuenta_digitos,
           digito_invalido, timeout_err
  );
endinterface

// File: rtl/pin_entry_collector.sv
// Collects N_DIGITS BCD keypad digits into a PIN word, with inter-digit timeout and clear key,
// and reports the assembled PIN plus its match against the card's PIN as a one-cycle strobe.
module pin_entry_collector #(
  parameter int N_DIGITS       = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TW             = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  pin_entry_collector_if.slave  bus
);
  localparam int              W        = 4 * N_DIGITS;
  localparam logic [2:0]      LAST_IDX = 3'(N_DIGITS - 1);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, REPORT, HOLD} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    buf_q, buf_d;
  logic [2:0]      count_q, count_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            listo_q, listo_d;
  logic            correcto_q, correcto_d;
  logic            inval_q, inval_d;
  logic            tout_q, tout_d;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    count_d    = count_q;
    timer_d    = timer_q;
    listo_d    = 1'b0;
    correcto_d = 1'b0;
    inval_d    = 1'b0;
    tout_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        buf_d   = '0;
        count_d = '0;
        timer_d = '0;
        if (bus.tarjeta_recibida) state_d = COLLECT;
      end

      COLLECT: begin
        if (!bus.tarjeta_recibida) begin
          state_d = IDLE;
          buf_d   = '0;
          count_d = '0;
          timer_d = '0;
        end else if (bus.borrar) begin
          // Clear key wins over a digit strobed in the same cycle.
          buf_d   = '0;
          count_d = '0;
          timer_d = '0;
        end else if (bus.digito_stb) begin
          timer_d = '0;
          if (bus.digito <= 4'd9) begin
            // Shift form keeps N_DIGITS=1 legal (no negative slice bound).
            buf_d   = (buf_q << 4) | W'(bus.digito);
            count_d = count_q + 3'd1;
            if (count_q == LAST_IDX) state_d = REPORT;
          end else begin
            inval_d = 1'b1;
          end
        end else if (count_q != '0) begin
          if (timer_q == TMO_LAST) begin
            tout_d  = 1'b1;
            buf_d   = '0;
            count_d = '0;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end

      REPORT: begin
        if (!bus.tarjeta_recibida) begin
          state_d = IDLE;
          buf_d   = '0;
          count_d = '0;
          timer_d = '0;
        end else begin
          listo_d    = 1'b1;
          correcto_d = (buf_q == bus.pin_ref);
          state_d    = HOLD;
        end
      end

      HOLD: begin
        // Keypad activity is ignored until the controller re-arms us.
        if (!bus.tarjeta_recibida) begin
          state_d = IDLE;
          buf_d   = '0;
          count_d = '0;
          timer_d = '0;
        end else if (bus.reintento) begin
          state_d = COLLECT;
          buf_d   = '0;
          count_d = '0;
          timer_d = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      count_q    <= '0;
      timer_q    <= '0;
      listo_q    <= 1'b0;
      correcto_q <= 1'b0;
      inval_q    <= 1'b0;
      tout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      count_q    <= count_d;
      timer_q    <= timer_d;
      listo_q    <= listo_d;
      correcto_q <= correcto_d;
      inval_q    <= inval_d;
      tout_q     <= tout_d;
    end
  end

  assign bus.pin_ingresado   = buf_q;
  assign bus.cuenta_digitos  = count_q;
  assign bus.pin_listo       = listo_q;
  assign bus.pin_correcto    = correcto_q;
  assign bus.digito_invalido = inval_q;
  assign bus.timeout_err     = tout_q;
endmodule

// File: tb/tb_pin_entry_collector.sv
// Scoreboard bench for pin_entry_collector: directed keypad sequences push expected strobes,
// a negedge monitor pops and compares whenever the collector pulses an output.
module tb_pin_entry_collector;
  localparam int N_DIGITS       = 4;
  localparam int TIMEOUT_CYCLES = 1000;
  localparam int TW             = 10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  int   stray_correcto = 0;

  typedef struct {
    logic [15:0] pin;
    logic        ok;
    int          due;
  } listo_exp_t;

  listo_exp_t listo_q[$];
  int         inval_q[$];
  int         tout_q[$];

  pin_entry_collector_if #(.N_DIGITS(N_DIGITS)) bus ();

  pin_entry_collector #(
    .N_DIGITS(N_DIGITS), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TW(TW)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_digit(input logic [3:0] d);
    bus.digito     = d;
    bus.digito_stb = 1'b1;
    tick();
    bus.digito_stb = 1'b0;
  endtask

  task automatic pulse_reintento();
    bus.reintento = 1'b1;
    tick();
    bus.reintento = 1'b0;
  endtask

  // Call in the same cycle the final digit is strobed: pin_listo is due two cycles later.
  task automatic expect_listo(input logic [15:0] pin, input logic ok);
    listo_exp_t e;
    e.pin = pin;
    e.ok  = ok;
    e.due = cyc + 2;
    listo_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (bus.pin_listo) begin
        if (listo_q.size() == 0) check("listo_unexpected", 32'(bus.pin_listo), 32'd0);
        else begin
          listo_exp_t e;
          e = listo_q.pop_front();
          check("listo_pin", 32'(bus.pin_ingresado), 32'(e.pin));
          check("listo_correcto", 32'(bus.pin_correcto), 32'(e.ok));
          check("listo_latency", 32'(cyc), 32'(e.due));
        end
      end else if (bus.pin_correcto) begin
        stray_correcto++;
      end
      if (bus.digito_invalido) begin
        if (inval_q.size() == 0) check("inval_unexpected", 32'(bus.digito_invalido), 32'd0);
        else check("inval_cycle", 32'(cyc), 32'(inval_q.pop_front()));
      end
      if (bus.timeout_err) begin
        if (tout_q.size() == 0) check("tout_unexpected", 32'(bus.timeout_err), 32'd0);
        else check("tout_cycle", 32'(cyc), 32'(tout_q.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tarjeta_recibida = 1'b0;
    bus.pin_ref          = 16'h1234;
    bus.digito           = 4'd0;
    bus.digito_stb       = 1'b0;
    bus.borrar           = 1'b0;
    bus.reintento        = 1'b0;

    // Reset state
    tick(3);
    check("rst_pin", 32'(bus.pin_ingresado), 32'h0);
    check("rst_count", 32'(bus.cuenta_digitos), 32'd0);
    check("rst_pulses", {28'd0, bus.pin_listo, bus.pin_correcto, bus.digito_invalido, bus.timeout_err}, 32'd0);
    reset = 1'b1;
    tick();

    // Digits without a card are not collected
    send_digit(4'd3);
    tick();
    check("idle_count", 32'(bus.cuenta_digitos), 32'd0);

    // T1: correct PIN
    bus.tarjeta_recibida = 1'b1;
    tick();
    send_digit(4'd1);
    send_digit(4'd2);
    send_digit(4'd3);
    expect_listo(16'h1234, 1'b1);
    send_digit(4'd4);
    tick(3);
    check("t1_hold_count", 32'(bus.cuenta_digitos), 32'd4);
    check("t1_hold_pin", 32'(bus.pin_ingresado), 32'h1234);

    // T2: wrong PIN, HOLD ignores keypad, retry succeeds
    pulse_reintento();
    check("t2_rearm_count", 32'(bus.cuenta_digitos), 32'd0);
    send_digit(4'd1);
    send_digit(4'd2);
    send_digit(4'd3);
    expect_listo(16'h1235, 1'b0);
    send_digit(4'd5);
    tick(3);
    send_digit(4'd7);
    bus.borrar = 1'b1;
    tick();
    bus.borrar = 1'b0;
    tick();
    check("t2_hold_count", 32'(bus.cuenta_digitos), 32'd4);
    check("t2_hold_pin", 32'(bus.pin_ingresado), 32'h1235);
    pulse_reintento();
    send_digit(4'd1);
    send_digit(4'd2);
    send_digit(4'd3);
    expect_listo(16'h1234, 1'b1);
    send_digit(4'd4);
    tick(3);

    // T3: clear key beats a same-cycle digit
    pulse_reintento();
    send_digit(4'd1);
    send_digit(4'd2);
    check("t3_partial_pin", 32'(bus.pin_ingresado), 32'h0012);
    bus.borrar = 1'b1;
    send_digit(4'd9);
    bus.borrar = 1'b0;
    check("t3_clr_count", 32'(bus.cuenta_digitos), 32'd0);
    check("t3_clr_pin", 32'(bus.pin_ingresado), 32'h0);
    send_digit(4'd5);
    send_digit(4'd6);
    send_digit(4'd7);
    expect_listo(16'h5678, 1'b0);
    send_digit(4'd8);
    tick(3);

    // T4: no timeout while empty, then one timeout after a single digit
    pulse_reintento();
    tick(TIMEOUT_CYCLES + 100);
    check("t4_empty_count", 32'(bus.cuenta_digitos), 32'd0);
    tout_q.push_back(cyc + 1 + TIMEOUT_CYCLES);
    send_digit(4'd1);
    tick(TIMEOUT_CYCLES - 2);
    check("t4_before_tout", 32'(bus.cuenta_digitos), 32'd1);
    tick(5);
    check("t4_after_count", 32'(bus.cuenta_digitos), 32'd0);
    check("t4_after_pin", 32'(bus.pin_ingresado), 32'h0);

    // T5: non-BCD digit rejected, entry continues
    send_digit(4'd1);
    inval_q.push_back(cyc + 1);
    send_digit(4'hA);
    check("t5_inval_count", 32'(bus.cuenta_digitos), 32'd1);
    check("t5_inval_pin", 32'(bus.pin_ingresado), 32'h0001);
    send_digit(4'd2);
    send_digit(4'd3);
    expect_listo(16'h1234, 1'b1);
    send_digit(4'd4);
    tick(3);

    // T6: card removal mid-entry, then async reset mid-entry
    pulse_reintento();
    send_digit(4'd1);
    send_digit(4'd2);
    send_digit(4'd3);
    check("t6_count3", 32'(bus.cuenta_digitos), 32'd3);
    bus.tarjeta_recibida = 1'b0;
    tick();
    check("t6_rm_count", 32'(bus.cuenta_digitos), 32'd0);
    check("t6_rm_pin", 32'(bus.pin_ingresado), 32'h0);
    tick(3);
    bus.tarjeta_recibida = 1'b1;
    tick();
    send_digit(4'd4);
    send_digit(4'd5);
    check("t6_count2", 32'(bus.cuenta_digitos), 32'd2);
    #2 reset = 1'b0;
    #1;
    check("t6_arst_count", 32'(bus.cuenta_digitos), 32'd0);
    check("t6_arst_pin", 32'(bus.pin_ingresado), 32'h0);
    tick(2);
    reset = 1'b1;
    tick(5);

    check("pending_listo", 32'(listo_q.size()), 32'd0);
    check("pending_inval", 32'(inval_q.size()), 32'd0);
    check("pending_tout", 32'(tout_q.size()), 32'd0);
    check("stray_correcto", 32'(stray_correcto), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
